// File: rtl/fir_controller.sv
// Sequencer for a single-MAC FIR datapath: accepts one sample, walks all taps,
// drains the multiplier pipe, then holds the result until downstream takes it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; in_ready high
// MAC   | one tap per cycle, address = tap index 0..FIR_size-1
// DRAIN | last product enters the accumulator, multiplier pipe zeroed
// DONE  | result valid on dout; a new sample may be taken when out_ready
module fir_controller #(
   parameter int FIR_size  = 64,
   parameter int AddrWidth = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 shift,
   output logic                 flush,
   output logic                 freeze,
   output logic [AddrWidth-1:0] address,
   output logic                 busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MAC   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [AddrWidth-1:0] LAST_TAP = AddrWidth'(FIR_size - 1);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [AddrWidth-1:0] addr_nxt;
   logic                 accept;

   // Outputs are gated by rst so the datapath sees all-quiet controls the
   // instant reset asserts, not one edge later.
   always_comb begin
      in_ready  = rst & ((state == IDLE) | ((state == DONE) & out_ready));
      accept    = in_valid & in_ready;
      shift     = accept;
      flush     = accept;
      freeze    = rst & ((state == DRAIN) | (state == DONE));
      out_valid = rst & (state == DONE);
      busy      = rst & (state != IDLE);
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = MAC;
         end
         MAC: begin
            if (address == LAST_TAP) begin
               state_nxt = DRAIN;
            end else begin
               addr_nxt = address + 1'b1;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            // A sample taken straight from DONE skips IDLE to keep 66-cycle throughput.
            if (accept) begin
               state_nxt = MAC;
            end else if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         address <= '0;
      end else begin
         state   <= state_nxt;
         address <= addr_nxt;
      end
   end

endmodule

// File: tb/tb_fir_controller.sv
// Bench for fir_controller: a cycle-phase reference model checks every output,
// and a small behavioural FIR datapath checks end-to-end results.
module tb_fir_controller;

   localparam int N  = 64;
   localparam int AW = 6;
   localparam int VW = AW + 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic          in_ready;
   logic          out_valid;
   logic          shift;
   logic          flush;
   logic          freeze;
   logic [AW-1:0] address;
   logic          busy;

   int checks = 0;
   int errors = 0;

   fir_controller #(.FIR_size(N), .AddrWidth(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .shift(shift),
      .flush(flush), .freeze(freeze), .address(address), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [VW-1:0] dut_vec;
   assign dut_vec = {in_ready, out_valid, shift, flush, freeze, busy, address};

   // Reference model: p = cycles since the sample was accepted (0 = idle).
   // Taps run on p = 1..N, drain on N+1, result held from N+2 on.
   function automatic logic [VW-1:0] exp_vec(int p, logic iv, logic ordy, logic r);
      logic          ir;
      logic          acc;
      logic [AW-1:0] a;
      if (!r) return '0;
      ir  = (p == 0) || (p >= N + 2 && ordy);
      acc = iv && ir;
      a   = (p >= 1 && p <= N) ? AW'(p - 1) : '0;
      return {ir, logic'(p >= N + 2), acc, acc, logic'(p >= N + 1), logic'(p != 0), a};
   endfunction

   function automatic int next_p(int p, logic iv, logic ordy, logic r);
      if (!r) return 0;
      if (iv && ((p == 0) || (p >= N + 2 && ordy))) return 1;
      if (p == 0) return 0;
      if (p >= N + 2) return ordy ? 0 : N + 2;
      return p + 1;
   endfunction

   // Behavioural datapath driven by the controller outputs.
   logic               dp_clr;
   logic signed [15:0] din;
   logic signed [15:0] coef [N];
   logic signed [15:0] xbuf [N];
   logic signed [31:0] prod;
   logic signed [39:0] acc;

   always @(posedge clk) begin
      if (dp_clr) begin
         for (int k = 0; k < N; k++) xbuf[k] <= '0;
         prod <= '0;
         acc  <= '0;
      end else begin
         if (shift) begin
            for (int k = N - 1; k > 0; k--) xbuf[k] <= xbuf[k-1];
            xbuf[0] <= din;
         end
         if (flush) begin
            prod <= '0;
            acc  <= '0;
         end else begin
            prod <= freeze ? 32'sd0 : 32'(xbuf[address]) * 32'(coef[address]);
            acc  <= acc + 40'(prod);
         end
      end
   end

   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_initial got %h exp 0", dut_vec);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_held got %h exp 0", dut_vec);
      end
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (address !== AW'(20) || busy !== 1'b1) begin
         errors++; $display("FAIL reset_pre_addr got addr %0d busy %b exp 20 1", address, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_mid_mac got %h exp 0", dut_vec);
      end
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1;
      #1;
      checks++;
      if (shift !== 1'b1 || flush !== 1'b1 || address !== '0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_accept got shift %b flush %b addr %0d ov %b exp 1 1 0 0",
                            shift, flush, address, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (address !== '0 || busy !== 1'b1 || shift !== 1'b0) begin
         errors++; $display("FAIL reset_after_accept got addr %0d busy %b shift %b exp 0 1 0",
                            address, busy, shift);
      end
   endtask

   task automatic test_single();
      int p = 0;
      int nshift = 0;
      int first_ov = -1;
      int last_busy = -1;
      do_reset();
      for (int cyc = 0; cyc <= 72; cyc++) begin
         in_valid  = (cyc == 0);
         out_ready = 1'b0;
         #1;
         checks++;
         if (dut_vec !== exp_vec(p, in_valid, out_ready, rst)) begin
            errors++; $display("FAIL single cyc %0d got %h exp %h", cyc, dut_vec,
                               exp_vec(p, in_valid, out_ready, rst));
         end
         if (shift) nshift++;
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (busy) last_busy = cyc;
         p = next_p(p, in_valid, out_ready, rst);
         @(posedge clk); #1;
      end
      checks++;
      if (nshift !== 1 || first_ov !== 66) begin
         errors++; $display("FAIL single_latency got shifts %0d first_ov %0d exp 1 66", nshift, first_ov);
      end
      checks++;
      if (last_busy !== 72) begin
         errors++; $display("FAIL single_busy got last busy cyc %0d exp 72", last_busy);
      end
   endtask

   task automatic test_backpressure();
      int p = 0;
      int held = 0;
      do_reset();
      for (int cyc = 0; cyc <= 77; cyc++) begin
         in_valid  = (cyc == 0) || (cyc >= 66);
         out_ready = (cyc >= 76);
         #1;
         checks++;
         if (dut_vec !== exp_vec(p, in_valid, out_ready, rst)) begin
            errors++; $display("FAIL backpressure cyc %0d got %h exp %h", cyc, dut_vec,
                               exp_vec(p, in_valid, out_ready, rst));
         end
         if (cyc >= 66 && cyc <= 75 && out_valid && freeze && !in_ready && !shift) held++;
         if (cyc == 76) begin
            checks++;
            if (shift !== 1'b1 || out_valid !== 1'b1) begin
               errors++; $display("FAIL backpressure_release got shift %b ov %b exp 1 1", shift, out_valid);
            end
         end
         p = next_p(p, in_valid, out_ready, rst);
         @(posedge clk); #1;
      end
      checks++;
      if (held !== 10) begin
         errors++; $display("FAIL backpressure_hold got %0d cycles exp 10", held);
      end
   endtask

   task automatic test_back_to_back();
      int p = 0;
      int q[$];
      int bad_gap = 0;
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         #1;
         checks++;
         if (dut_vec !== exp_vec(p, in_valid, out_ready, rst)) begin
            errors++; $display("FAIL back_to_back cyc %0d got %h exp %h", cyc, dut_vec,
                               exp_vec(p, in_valid, out_ready, rst));
         end
         if (shift) q.push_back(cyc);
         p = next_p(p, in_valid, out_ready, rst);
         @(posedge clk); #1;
      end
      for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 66) bad_gap++;
      checks++;
      if (q.size() !== 7 || bad_gap !== 0 || q[0] !== 0) begin
         errors++; $display("FAIL back_to_back_period got shifts %0d bad gaps %0d exp 7 0",
                            q.size(), bad_gap);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_mac_in_valid();
      int p = 0;
      int q[$];
      do_reset();
      for (int cyc = 0; cyc <= 80; cyc++) begin
         in_valid  = (cyc == 0) || (p >= 31);
         out_ready = (cyc >= 70);
         #1;
         checks++;
         if (dut_vec !== exp_vec(p, in_valid, out_ready, rst)) begin
            errors++; $display("FAIL mac_in_valid cyc %0d got %h exp %h", cyc, dut_vec,
                               exp_vec(p, in_valid, out_ready, rst));
         end
         if (shift) q.push_back(cyc);
         p = next_p(p, in_valid, out_ready, rst);
         @(posedge clk); #1;
      end
      checks++;
      if (q.size() !== 2 || q[0] !== 0 || q[1] !== 70) begin
         errors++; $display("FAIL mac_in_valid_shifts got %0d shifts exp 2 at 0 and 70", q.size());
      end
      in_valid = 1'b0;
   endtask

   task automatic run_datapath(int nsamp, logic unit);
      logic signed [15:0] xs [];
      longint ref_y;
      int fed = 0;
      int got = 0;
      int cyc = 0;
      xs = new[nsamp];
      for (int i = 0; i < nsamp; i++)
         xs[i] = unit ? ((i == 0) ? 16'sd1 : 16'sd0) : 16'(int'($urandom_range(0, 2000)) - 1000);
      for (int k = 0; k < N; k++)
         coef[k] = unit ? 16'sd1 : 16'(int'($urandom_range(0, 200)) - 100);
      do_reset();
      dp_clr = 1'b1;
      @(posedge clk); #1;
      dp_clr = 1'b0;
      out_ready = 1'b1;
      while (got < nsamp && cyc < nsamp * 70 + 100) begin
         in_valid = (fed < nsamp);
         din      = (fed < nsamp) ? xs[fed] : 16'sd0;
         #1;
         if (out_valid) begin
            ref_y = 0;
            for (int k = 0; k < N; k++)
               if (got - k >= 0) ref_y += longint'(coef[k]) * longint'(xs[got - k]);
            checks++;
            if (longint'(acc) !== ref_y) begin
               errors++; $display("FAIL datapath out %0d got %0d exp %0d", got + 1, acc, ref_y);
            end
            got++;
         end
         if (shift) fed++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== nsamp) begin
         errors++; $display("FAIL datapath_timeout got %0d outputs exp %0d", got, nsamp);
      end
   endtask

   task automatic test_datapath();
      run_datapath(65, 1'b1);
      run_datapath(6, 1'b0);
   endtask

   task automatic test_random();
      int p = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst       = ($urandom_range(0, 299) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         #1;
         checks++;
         if (dut_vec !== exp_vec(p, in_valid, out_ready, rst)) begin
            errors++; $display("FAIL random cyc %0d got %h exp %h", cyc, dut_vec,
                               exp_vec(p, in_valid, out_ready, rst));
         end
         p = next_p(p, in_valid, out_ready, rst);
         @(posedge clk); #1;
      end
      rst = 1'b1; in_valid = 1'b0;
   endtask

   initial begin
      dp_clr = 1'b0;
      din    = '0;
      for (int k = 0; k < N; k++) coef[k] = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_mac_in_valid();
      test_datapath();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
